// File: rtl/simple_processor_pkg.sv
// simple_processor_pkg
// Shared types and constants for the simple processor memory subsystem.
// Provides the default bus widths, the default arbiter timeout, the
// arbiter FSM state type and the requester identifier used by the
// round-robin grant logic.
package simple_processor_pkg;

    localparam int ADDR_WIDTH      = 16;
    localparam int DATA_WIDTH      = 16;
    localparam int DEFAULT_TIMEOUT = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } arb_state_e;

    typedef enum logic {
        SRC_IMEM = 1'b0,
        SRC_DMEM = 1'b1
    } grant_src_e;

endpackage

// File: rtl/mem_port_arbiter_rr.sv
// rr_arbiter2
// Two-input round-robin grant selector for the memory port arbiter.
// A lone request is granted directly; when both sides request in the same
// cycle the side that was not granted last wins. The last_grant register
// is updated whenever a grant is issued and resets to the instruction side,
// so the very first tie goes to the data side.
// Ports:
//   clk, rst               clock and synchronous active-high reset
//   imem_req, dmem_req     requests eligible for a grant this cycle
//   grant_imem, grant_dmem one-hot (or zero) combinational grant
module rr_arbiter2
    import simple_processor_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic imem_req,
    input  logic dmem_req,
    output logic grant_imem,
    output logic grant_dmem
);

    grant_src_e last_grant;

    // Pick the winner for this cycle. On a tie the side opposite to the
    // previous winner is chosen; otherwise whichever side is asking wins.
    always_comb begin
        grant_imem = 1'b0;
        grant_dmem = 1'b0;
        if (imem_req && dmem_req) begin
            if (last_grant == SRC_IMEM) begin
                grant_dmem = 1'b1;
            end else begin
                grant_imem = 1'b1;
            end
        end else begin
            grant_imem = imem_req;
            grant_dmem = dmem_req;
        end
    end

    // Remember who won the most recent grant so the next tie can be
    // resolved in the other direction.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= SRC_IMEM;
        end else if (grant_dmem) begin
            last_grant <= SRC_DMEM;
        end else if (grant_imem) begin
            last_grant <= SRC_IMEM;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one memory port between the instruction and data sides of the
// simple processor. One transaction is outstanding at a time. The winning
// request is latched into registered mem_* outputs, which stay stable until
// the memory acknowledges or the wait counter times out. Completion acks and
// read data back to the requesters are combinational in the completing
// cycle; read data is forced to zero whenever its ack is low.
// Ports:
//   clk_i, rst_i                       clock, synchronous active-high reset
//   imem_req_i, imem_addr_i            instruction fetch request
//   imem_rdata_o, imem_ack_o           instruction completion
//   dmem_req_i, dmem_we_i, dmem_addr_i, dmem_wdata_i   data request
//   dmem_rdata_o, dmem_ack_o           data completion
//   mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o       shared port request
//   mem_rdata_i, mem_ack_i             shared port response
//   err_o                              pulse on a timed-out access
module mem_port_arbiter
    import simple_processor_pkg::*;
#(
    parameter int MEM_ADDR_WIDTH = ADDR_WIDTH,
    parameter int MEM_DATA_WIDTH = DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      imem_req_i,
    input  logic [MEM_ADDR_WIDTH-1:0] imem_addr_i,
    output logic [MEM_DATA_WIDTH-1:0] imem_rdata_o,
    output logic                      imem_ack_o,
    input  logic                      dmem_req_i,
    input  logic                      dmem_we_i,
    input  logic [MEM_ADDR_WIDTH-1:0] dmem_addr_i,
    input  logic [MEM_DATA_WIDTH-1:0] dmem_wdata_i,
    output logic [MEM_DATA_WIDTH-1:0] dmem_rdata_o,
    output logic                      dmem_ack_o,
    output logic                      mem_req_o,
    output logic                      mem_we_o,
    output logic [MEM_ADDR_WIDTH-1:0] mem_addr_o,
    output logic [MEM_DATA_WIDTH-1:0] mem_wdata_o,
    input  logic [MEM_DATA_WIDTH-1:0] mem_rdata_i,
    input  logic                      mem_ack_i,
    output logic                      err_o
);

    // The counter value seen during the last permitted wait cycle; reaching
    // it without an ack means the access is abandoned in that cycle.
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    arb_state_e state;
    logic [7:0] wait_cnt;

    logic in_grant;
    logic timeout;
    logic finish;
    logic arb_imem_req;
    logic arb_dmem_req;
    logic grant_imem;
    logic grant_dmem;

    assign in_grant = (state == GNT_I) || (state == GNT_D);
    assign timeout  = in_grant && !mem_ack_i && (wait_cnt == TIMEOUT_LAST);
    assign finish   = in_grant && (mem_ack_i || timeout);

    // Decide which requests may compete for the port this cycle. From IDLE
    // both sides compete; when the current access completes only the other
    // side may take over, so the side just served cannot re-win immediately.
    always_comb begin
        arb_imem_req = 1'b0;
        arb_dmem_req = 1'b0;
        if (state == IDLE) begin
            arb_imem_req = imem_req_i;
            arb_dmem_req = dmem_req_i;
        end else if (finish && state == GNT_I) begin
            arb_dmem_req = dmem_req_i;
        end else if (finish && state == GNT_D) begin
            arb_imem_req = imem_req_i;
        end
    end

    rr_arbiter2 u_rr (
        .clk        (clk_i),
        .rst        (rst_i),
        .imem_req   (arb_imem_req),
        .dmem_req   (arb_dmem_req),
        .grant_imem (grant_imem),
        .grant_dmem (grant_dmem)
    );

    // Completion signalling back to the requesters. Acks fire in the cycle
    // the access finishes (memory ack or timeout) and are suppressed while
    // reset is asserted so an interrupted access never completes. Read data
    // only passes through on a genuine memory ack.
    assign imem_ack_o   = !rst_i && finish && (state == GNT_I);
    assign dmem_ack_o   = !rst_i && finish && (state == GNT_D);
    assign err_o        = !rst_i && timeout;
    assign imem_rdata_o = (imem_ack_o && mem_ack_i) ? mem_rdata_i : '0;
    assign dmem_rdata_o = (dmem_ack_o && mem_ack_i) ? mem_rdata_i : '0;

    // Main arbiter FSM with the registered memory port. A new grant loads
    // the winner's request into the port registers and clears the wait
    // counter; instruction grants always present a read with zero write
    // data. When an access finishes with nobody waiting, the port is
    // cleared and the FSM returns to IDLE. While waiting, the port holds
    // steady and the counter advances.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            wait_cnt    <= 8'd0;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
        end else if (state == IDLE || finish) begin
            if (grant_dmem) begin
                state       <= GNT_D;
                wait_cnt    <= 8'd0;
                mem_req_o   <= 1'b1;
                mem_we_o    <= dmem_we_i;
                mem_addr_o  <= dmem_addr_i;
                mem_wdata_o <= dmem_wdata_i;
            end else if (grant_imem) begin
                state       <= GNT_I;
                wait_cnt    <= 8'd0;
                mem_req_o   <= 1'b1;
                mem_we_o    <= 1'b0;
                mem_addr_o  <= imem_addr_i;
                mem_wdata_o <= '0;
            end else if (finish) begin
                state       <= IDLE;
                wait_cnt    <= 8'd0;
                mem_req_o   <= 1'b0;
                mem_we_o    <= 1'b0;
                mem_addr_o  <= '0;
                mem_wdata_o <= '0;
            end
        end else begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Self-checking bench for mem_port_arbiter. The bench plays the role of
// both requesters and the memory. A table of single transactions with
// hand-computed expectations is applied in a loop, followed by directed
// sequences for ties, back-to-back grants, stray acks, dropped requests
// and reset in the middle of an access.
module tb_mem_port_arbiter;

    logic        clk_i;
    logic        rst_i;
    logic        imem_req_i;
    logic [15:0] imem_addr_i;
    logic [15:0] imem_rdata_o;
    logic        imem_ack_o;
    logic        dmem_req_i;
    logic        dmem_we_i;
    logic [15:0] dmem_addr_i;
    logic [15:0] dmem_wdata_i;
    logic [15:0] dmem_rdata_o;
    logic        dmem_ack_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [15:0] mem_addr_o;
    logic [15:0] mem_wdata_o;
    logic [15:0] mem_rdata_i;
    logic        mem_ack_i;
    logic        err_o;

    int checks;
    int errors;

    typedef struct {
        logic        use_d;
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        int          lat;
        logic [15:0] resp;
        logic        exp_we;
        logic [15:0] exp_wdata;
        logic [15:0] exp_rdata;
        logic        exp_err;
        int          exp_ack_cycle;
    } vec_t;

    vec_t vecs[8];

    mem_port_arbiter dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .imem_req_i   (imem_req_i),
        .imem_addr_i  (imem_addr_i),
        .imem_rdata_o (imem_rdata_o),
        .imem_ack_o   (imem_ack_o),
        .dmem_req_i   (dmem_req_i),
        .dmem_we_i    (dmem_we_i),
        .dmem_addr_i  (dmem_addr_i),
        .dmem_wdata_i (dmem_wdata_i),
        .dmem_rdata_o (dmem_rdata_o),
        .dmem_ack_o   (dmem_ack_o),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_rdata_i  (mem_rdata_i),
        .mem_ack_i    (mem_ack_i),
        .err_o        (err_o)
    );

    // Free-running 10 ns clock.
    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    // Safety net so the run can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired actual=running required=finished");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h", name, actual, expected);
        end
    endtask

    task automatic checkOutputBit(input string name, input logic actual, input logic expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%b required=%b", name, actual, expected);
        end
    endtask

    // Advance to just after the next rising edge; inputs are driven here.
    task automatic stepCycle();
        @(posedge clk_i);
        #1;
    endtask

    function automatic vec_t mkVec(input logic use_d, input logic we, input logic [15:0] addr,
                                   input logic [15:0] wdata, input int lat, input logic [15:0] resp,
                                   input logic exp_we, input logic [15:0] exp_wdata,
                                   input logic [15:0] exp_rdata, input logic exp_err,
                                   input int exp_ack_cycle);
        vec_t v;
        v.use_d         = use_d;
        v.we            = we;
        v.addr          = addr;
        v.wdata         = wdata;
        v.lat           = lat;
        v.resp          = resp;
        v.exp_we        = exp_we;
        v.exp_wdata     = exp_wdata;
        v.exp_rdata     = exp_rdata;
        v.exp_err       = exp_err;
        v.exp_ack_cycle = exp_ack_cycle;
        return v;
    endfunction

    // Run one isolated transaction. lat is the grant cycle in which the
    // memory acks (0 = never). Non-ack cycles present garbage read data so
    // the zero-when-no-ack rule is exercised.
    task automatic applyStimulus(input vec_t v);
        logic acked;
        stepCycle();
        imem_req_i   = !v.use_d;
        dmem_req_i   = v.use_d;
        imem_addr_i  = v.use_d ? (v.addr ^ 16'hFFFF) : v.addr;
        dmem_addr_i  = v.use_d ? v.addr : (v.addr ^ 16'hFFFF);
        dmem_we_i    = v.we;
        dmem_wdata_i = v.wdata;
        mem_ack_i    = 1'b0;
        mem_rdata_i  = 16'h0000;
        #1;
        checkOutputBit("idle_mem_req", mem_req_o, 1'b0);
        for (int n = 1; n <= v.exp_ack_cycle; n++) begin
            stepCycle();
            mem_ack_i   = (n == v.lat);
            mem_rdata_i = (n == v.lat) ? v.resp : 16'hDEAD;
            #1;
            acked = (n == v.exp_ack_cycle);
            checkOutputBit("mem_req", mem_req_o, 1'b1);
            checkOutput("mem_addr", mem_addr_o, v.addr);
            checkOutputBit("mem_we", mem_we_o, v.exp_we);
            checkOutput("mem_wdata", mem_wdata_o, v.exp_wdata);
            checkOutputBit("imem_ack", imem_ack_o, acked && !v.use_d);
            checkOutputBit("dmem_ack", dmem_ack_o, acked && v.use_d);
            checkOutput("imem_rdata", imem_rdata_o, (acked && !v.use_d) ? v.exp_rdata : 16'h0000);
            checkOutput("dmem_rdata", dmem_rdata_o, (acked && v.use_d) ? v.exp_rdata : 16'h0000);
            checkOutputBit("err", err_o, acked ? v.exp_err : 1'b0);
        end
        stepCycle();
        imem_req_i  = 1'b0;
        dmem_req_i  = 1'b0;
        mem_ack_i   = 1'b0;
        mem_rdata_i = 16'h0000;
        #1;
        checkOutputBit("post_mem_req", mem_req_o, 1'b0);
        checkOutputBit("post_err", err_o, 1'b0);
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        rst_i        = 1'b1;
        imem_req_i   = 1'b0;
        imem_addr_i  = 16'h0000;
        dmem_req_i   = 1'b0;
        dmem_we_i    = 1'b0;
        dmem_addr_i  = 16'h0000;
        dmem_wdata_i = 16'h0000;
        mem_rdata_i  = 16'h0000;
        mem_ack_i    = 1'b0;

        //                use_d we  addr      wdata    lat resp      ewe  ewdata    erdata    eerr ack
        vecs[0] = mkVec(1'b0, 1'b0, 16'h0010, 16'h0000, 3, 16'hABCD, 1'b0, 16'h0000, 16'hABCD, 1'b0, 3);
        vecs[1] = mkVec(1'b1, 1'b1, 16'h0020, 16'h1234, 4, 16'h0000, 1'b1, 16'h1234, 16'h0000, 1'b0, 4);
        vecs[2] = mkVec(1'b1, 1'b0, 16'h0030, 16'h3333, 1, 16'hBEEF, 1'b0, 16'h3333, 16'hBEEF, 1'b0, 1);
        vecs[3] = mkVec(1'b0, 1'b1, 16'h0040, 16'h7777, 2, 16'h1111, 1'b0, 16'h0000, 16'h1111, 1'b0, 2);
        vecs[4] = mkVec(1'b0, 1'b0, 16'h0050, 16'h0000, 0, 16'h5A5A, 1'b0, 16'h0000, 16'h0000, 1'b1, 16);
        vecs[5] = mkVec(1'b1, 1'b1, 16'h0060, 16'h9999, 0, 16'h5A5A, 1'b1, 16'h9999, 16'h0000, 1'b1, 16);
        vecs[6] = mkVec(1'b1, 1'b0, 16'h0070, 16'h0000, 16, 16'h2222, 1'b0, 16'h0000, 16'h2222, 1'b0, 16);
        vecs[7] = mkVec(1'b0, 1'b0, 16'h0080, 16'h0000, 15, 16'h3C3C, 1'b0, 16'h0000, 16'h3C3C, 1'b0, 15);

        // Reset state
        stepCycle();
        stepCycle();
        rst_i = 1'b0;
        #1;
        checkOutputBit("rst_mem_req", mem_req_o, 1'b0);
        checkOutputBit("rst_mem_we", mem_we_o, 1'b0);
        checkOutput("rst_mem_addr", mem_addr_o, 16'h0000);
        checkOutput("rst_mem_wdata", mem_wdata_o, 16'h0000);
        checkOutputBit("rst_imem_ack", imem_ack_o, 1'b0);
        checkOutputBit("rst_dmem_ack", dmem_ack_o, 1'b0);
        checkOutput("rst_imem_rdata", imem_rdata_o, 16'h0000);
        checkOutput("rst_dmem_rdata", dmem_rdata_o, 16'h0000);
        checkOutputBit("rst_err", err_o, 1'b0);

        // Stray memory ack while idle
        stepCycle();
        mem_ack_i   = 1'b1;
        mem_rdata_i = 16'hFFFF;
        #1;
        checkOutputBit("stray_imem_ack", imem_ack_o, 1'b0);
        checkOutputBit("stray_dmem_ack", dmem_ack_o, 1'b0);
        checkOutputBit("stray_err", err_o, 1'b0);
        checkOutput("stray_imem_rdata", imem_rdata_o, 16'h0000);
        checkOutput("stray_dmem_rdata", dmem_rdata_o, 16'h0000);
        stepCycle();
        mem_ack_i   = 1'b0;
        mem_rdata_i = 16'h0000;
        #1;
        checkOutputBit("stray_mem_req", mem_req_o, 1'b0);

        // First tie after reset: DMEM first, then IMEM with no idle bubble
        stepCycle();
        imem_req_i   = 1'b1;
        imem_addr_i  = 16'h0100;
        dmem_req_i   = 1'b1;
        dmem_we_i    = 1'b0;
        dmem_addr_i  = 16'h0200;
        dmem_wdata_i = 16'h0000;
        stepCycle();
        checkOutputBit("tie1_mem_req", mem_req_o, 1'b1);
        checkOutput("tie1_mem_addr_d", mem_addr_o, 16'h0200);
        checkOutputBit("tie1_dmem_ack_wait", dmem_ack_o, 1'b0);
        stepCycle();
        mem_ack_i   = 1'b1;
        mem_rdata_i = 16'h0A0A;
        #1;
        checkOutputBit("tie1_dmem_ack", dmem_ack_o, 1'b1);
        checkOutput("tie1_dmem_rdata", dmem_rdata_o, 16'h0A0A);
        checkOutputBit("tie1_imem_ack_low", imem_ack_o, 1'b0);
        checkOutput("tie1_imem_rdata_low", imem_rdata_o, 16'h0000);
        stepCycle();
        dmem_req_i  = 1'b0;
        mem_ack_i   = 1'b0;
        mem_rdata_i = 16'h0000;
        #1;
        checkOutputBit("tie1_b2b_mem_req", mem_req_o, 1'b1);
        checkOutput("tie1_b2b_mem_addr_i", mem_addr_o, 16'h0100);
        checkOutputBit("tie1_b2b_mem_we", mem_we_o, 1'b0);
        stepCycle();
        mem_ack_i   = 1'b1;
        mem_rdata_i = 16'h0B0B;
        #1;
        checkOutputBit("tie1_imem_ack", imem_ack_o, 1'b1);
        checkOutput("tie1_imem_rdata", imem_rdata_o, 16'h0B0B);
        stepCycle();
        imem_req_i  = 1'b0;
        mem_ack_i   = 1'b0;
        mem_rdata_i = 16'h0000;
        #1;
        checkOutputBit("tie1_end_mem_req", mem_req_o, 1'b0);

        // Table of isolated transactions
        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i]);
        end

        // After a lone DMEM grant the next tie goes to IMEM, then DMEM back-to-back
        applyStimulus(vecs[2]);
        stepCycle();
        imem_req_i   = 1'b1;
        imem_addr_i  = 16'h0500;
        dmem_req_i   = 1'b1;
        dmem_we_i    = 1'b1;
        dmem_addr_i  = 16'h0600;
        dmem_wdata_i = 16'h6666;
        stepCycle();
        mem_ack_i   = 1'b1;
        mem_rdata_i = 16'h0D0D;
        #1;
        checkOutput("tie2_mem_addr_i", mem_addr_o, 16'h0500);
        checkOutputBit("tie2_mem_we", mem_we_o, 1'b0);
        checkOutput("tie2_mem_wdata", mem_wdata_o, 16'h0000);
        checkOutputBit("tie2_imem_ack", imem_ack_o, 1'b1);
        checkOutputBit("tie2_dmem_ack_low", dmem_ack_o, 1'b0);
        stepCycle();
        imem_req_i  = 1'b0;
        mem_ack_i   = 1'b0;
        mem_rdata_i = 16'h0000;
        #1;
        checkOutputBit("tie2_b2b_mem_req", mem_req_o, 1'b1);
        checkOutput("tie2_b2b_mem_addr_d", mem_addr_o, 16'h0600);
        checkOutputBit("tie2_b2b_mem_we", mem_we_o, 1'b1);
        checkOutput("tie2_b2b_mem_wdata", mem_wdata_o, 16'h6666);
        stepCycle();
        mem_ack_i = 1'b1;
        #1;
        checkOutputBit("tie2_dmem_ack", dmem_ack_o, 1'b1);
        checkOutput("tie2_dmem_rdata", dmem_rdata_o, 16'h0000);
        stepCycle();
        dmem_req_i = 1'b0;
        mem_ack_i  = 1'b0;
        #1;
        checkOutputBit("tie2_end_mem_req", mem_req_o, 1'b0);

        // Requester drops its request early; the access still completes
        stepCycle();
        imem_req_i  = 1'b1;
        imem_addr_i = 16'h0300;
        stepCycle();
        imem_req_i = 1'b0;
        #1;
        checkOutputBit("drop_mem_req", mem_req_o, 1'b1);
        checkOutput("drop_mem_addr", mem_addr_o, 16'h0300);
        stepCycle();
        mem_ack_i   = 1'b1;
        mem_rdata_i = 16'h0C0C;
        #1;
        checkOutputBit("drop_imem_ack", imem_ack_o, 1'b1);
        checkOutput("drop_imem_rdata", imem_rdata_o, 16'h0C0C);
        stepCycle();
        mem_ack_i   = 1'b0;
        mem_rdata_i = 16'h0000;
        #1;
        checkOutputBit("drop_end_mem_req", mem_req_o, 1'b0);

        // Reset in the middle of a data write abandons it without an ack
        stepCycle();
        dmem_req_i   = 1'b1;
        dmem_we_i    = 1'b1;
        dmem_addr_i  = 16'h0400;
        dmem_wdata_i = 16'h4444;
        stepCycle();
        checkOutputBit("midrst_mem_we", mem_we_o, 1'b1);
        checkOutput("midrst_mem_wdata", mem_wdata_o, 16'h4444);
        stepCycle();
        rst_i = 1'b1;
        #1;
        checkOutputBit("midrst_dmem_ack_during", dmem_ack_o, 1'b0);
        stepCycle();
        rst_i      = 1'b0;
        dmem_req_i = 1'b0;
        dmem_we_i  = 1'b0;
        #1;
        checkOutputBit("midrst_mem_req", mem_req_o, 1'b0);
        checkOutputBit("midrst_mem_we_after", mem_we_o, 1'b0);
        checkOutput("midrst_mem_addr", mem_addr_o, 16'h0000);
        checkOutput("midrst_mem_wdata_after", mem_wdata_o, 16'h0000);
        checkOutputBit("midrst_dmem_ack_after", dmem_ack_o, 1'b0);
        checkOutputBit("midrst_err", err_o, 1'b0);
        applyStimulus(vecs[1]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
